// File: rtl/data_mem_resp.sv
// data_mem_resp
//   Responder end of the pipeline's data-memory interface. A request is
//   captured in IDLE, held for LATENCY wait states, then serviced against a
//   word-organised RAM on the edge that enters RESP. RESP lasts one cycle.
//
//   Optional feature macro: DATA_MEM_RESP_ERR_CHECK_EN
//     defined   -> illegal count, misaligned or out-of-range requests answer
//                  ERR with no side effects
//     undefined -> count clamped to 4, offset forced aligned, address wraps
//
// Ports
//   clk                in  sole clock, rising edge
//   aresetn            in  asynchronous active-low reset
//   i_mem_req_addr     in  byte address
//   i_mem_req_wr_data  in  store data, right-aligned
//   i_mem_req_wr_en    in  1 = store, 0 = load
//   i_mem_req_count    in  bytes to access, 0 = no request
//   o_mem_res_rd_data  out load data, right-aligned, zero-extended
//   o_mem_res_code     out IDLE=0, BUSY=1, DONE=2, ERR=3
module data_mem_resp #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int MEM_COUNT_W = 3,
  parameter int MEM_CODE_W  = 2,
  parameter int DEPTH       = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic [ADDR_W-1:0]      i_mem_req_addr,
  input  logic [WORD_W-1:0]      i_mem_req_wr_data,
  input  logic                   i_mem_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_mem_req_count,
  output logic [WORD_W-1:0]      o_mem_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_mem_res_code
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [MEM_CODE_W-1:0] CODE_IDLE = MEM_CODE_W'(0);
  localparam logic [MEM_CODE_W-1:0] CODE_BUSY = MEM_CODE_W'(1);
  localparam logic [MEM_CODE_W-1:0] CODE_DONE = MEM_CODE_W'(2);
  localparam logic [MEM_CODE_W-1:0] CODE_ERR  = MEM_CODE_W'(3);
  localparam logic [3:0]            LAT       = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [3:0]        wait_cnt;

  logic              req_valid;
  logic [IDX_W-1:0]  in_idx;
  logic [1:0]        in_off;
  logic [2:0]        in_cnt;
  logic              in_err;

  logic [IDX_W-1:0]  lat_idx;
  logic [1:0]        lat_off;
  logic [2:0]        lat_cnt;
  logic              lat_err;
  logic              lat_we;
  logic [WORD_W-1:0] lat_wdata;

  logic              sel_in;
  logic [IDX_W-1:0]  acc_idx;
  logic [1:0]        acc_off;
  logic [2:0]        acc_cnt;
  logic              acc_err;
  logic              acc_we;
  logic [WORD_W-1:0] acc_wdata;

  logic              do_access;
  logic [3:0]        lane_en;
  logic [WORD_W-1:0] keep_bits;
  logic [4:0]        shift_amt;
  logic [WORD_W-1:0] wdata_lanes;
  logic [WORD_W-1:0] load_data;
  logic [WORD_W-1:0] resp_data;
  logic [MEM_CODE_W-1:0] resp_code;

  logic [WORD_W-1:0] mem [DEPTH];

  assign req_valid = (i_mem_req_count != '0);
  assign in_idx    = i_mem_req_addr[IDX_W+1:2];

  // Legality and lane decode happen on the raw request so that the latched
  // copy already carries the final count/offset/error decision.
  always_comb begin
    in_cnt = (i_mem_req_count >= MEM_COUNT_W'(4)) ? 3'd4 : 3'(i_mem_req_count);
    in_off = i_mem_req_addr[1:0];
    in_err = 1'b0;
`ifdef DATA_MEM_RESP_ERR_CHECK_EN
    if (!(i_mem_req_count == MEM_COUNT_W'(1) || i_mem_req_count == MEM_COUNT_W'(2) ||
          i_mem_req_count == MEM_COUNT_W'(4)))
      in_err = 1'b1;
    if (i_mem_req_count == MEM_COUNT_W'(2) && i_mem_req_addr[0])
      in_err = 1'b1;
    if (i_mem_req_count == MEM_COUNT_W'(4) && i_mem_req_addr[1:0] != 2'b00)
      in_err = 1'b1;
    if (i_mem_req_addr[ADDR_W-1:IDX_W+2] != '0)
      in_err = 1'b1;
`else
    if (in_cnt == 3'd2)
      in_off[0] = 1'b0;
    else if (in_cnt == 3'd4)
      in_off = 2'b00;
`endif
  end

`ifndef DATA_MEM_RESP_ERR_CHECK_EN
  // Upper address bits only matter for range checking; the address wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_mem_req_addr[ADDR_W-1:IDX_W+2];
`endif

  // With zero wait states the access happens on the capture edge itself, so
  // the live request is used instead of the not-yet-latched copy.
  assign sel_in    = (state == S_IDLE);
  assign acc_idx   = sel_in ? in_idx            : lat_idx;
  assign acc_off   = sel_in ? in_off            : lat_off;
  assign acc_cnt   = sel_in ? in_cnt            : lat_cnt;
  assign acc_err   = sel_in ? in_err            : lat_err;
  assign acc_we    = sel_in ? i_mem_req_wr_en   : lat_we;
  assign acc_wdata = sel_in ? i_mem_req_wr_data : lat_wdata;

  assign do_access = aresetn &&
                     (((state == S_IDLE) && req_valid && (LATENCY == 0)) ||
                      ((state == S_WAIT) && (wait_cnt == 4'd1)));

  // Lanes past byte 3 simply fall off the word.
  always_comb begin
    lane_en   = '0;
    keep_bits = '0;
    for (int i = 0; i < 4; i++) begin
      lane_en[i]          = (i >= int'(acc_off)) && (i < int'(acc_off) + int'(acc_cnt));
      keep_bits[8*i +: 8] = {8{i < int'(acc_cnt)}};
    end
  end

  assign shift_amt   = {acc_off, 3'b000};
  assign wdata_lanes = acc_wdata << shift_amt;
  assign load_data   = (mem[acc_idx] >> shift_amt) & keep_bits;
  assign resp_data   = (acc_we || acc_err) ? '0 : load_data;
  assign resp_code   = acc_err ? CODE_ERR : CODE_DONE;

  // RAM is never reset; byte-lane writes only on a legal store.
  always_ff @(posedge clk) begin
    if (do_access && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i])
          mem[acc_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  // Control FSM with registered response code and read data.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state             <= S_IDLE;
      wait_cnt          <= '0;
      o_mem_res_code    <= CODE_IDLE;
      o_mem_res_rd_data <= '0;
      lat_idx           <= '0;
      lat_off           <= '0;
      lat_cnt           <= '0;
      lat_err           <= 1'b0;
      lat_we            <= 1'b0;
      lat_wdata         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_idx   <= in_idx;
            lat_off   <= in_off;
            lat_cnt   <= in_cnt;
            lat_err   <= in_err;
            lat_we    <= i_mem_req_wr_en;
            lat_wdata <= i_mem_req_wr_data;
            if (LATENCY > 0) begin
              state          <= S_WAIT;
              wait_cnt       <= LAT;
              o_mem_res_code <= CODE_BUSY;
            end else begin
              state             <= S_RESP;
              o_mem_res_code    <= resp_code;
              o_mem_res_rd_data <= resp_data;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd1) begin
            state             <= S_RESP;
            o_mem_res_code    <= resp_code;
            o_mem_res_rd_data <= resp_data;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          state          <= S_IDLE;
          o_mem_res_code <= CODE_IDLE;
        end
        default: begin
          state          <= S_IDLE;
          o_mem_res_code <= CODE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp
//   Bench for data_mem_resp. The main instance (LATENCY=2) is driven with
//   directed and random requests; each request pushes its expected response,
//   computed from a byte-array memory model, into a queue that a monitor
//   pops whenever DONE/ERR appears. A second instance (LATENCY=0) covers
//   back-to-back held requests.
`timescale 1ns/1ps
module tb_data_mem_resp;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;
  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_BUSY = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;
  localparam logic [1:0] C_ERR  = 2'd3;

  typedef struct packed {
    logic [1:0]  code;
    logic [31:0] rd;
  } resp_t;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] addr, wdata, rdata;
  logic        we;
  logic [2:0]  cnt;
  logic [1:0]  code;
  logic [31:0] addr0, wdata0, rdata0;
  logic        we0;
  logic [2:0]  cnt0;
  logic [1:0]  code0;

  int          compared = 0;
  int          mismatched = 0;
  resp_t       exp_q[$];
  logic [7:0]  mem_model [4*DEPTH];

  always #5 clk = ~clk;

  data_mem_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .aresetn(aresetn),
    .i_mem_req_addr(addr), .i_mem_req_wr_data(wdata),
    .i_mem_req_wr_en(we), .i_mem_req_count(cnt),
    .o_mem_res_rd_data(rdata), .o_mem_res_code(code)
  );

  data_mem_resp #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .aresetn(aresetn),
    .i_mem_req_addr(addr0), .i_mem_req_wr_data(wdata0),
    .i_mem_req_wr_en(we0), .i_mem_req_count(cnt0),
    .o_mem_res_rd_data(rdata0), .o_mem_res_code(code0)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkCode(input string name, input logic [1:0] act, input logic [1:0] exp);
    checkOutput(name, {30'b0, act}, {30'b0, exp});
  endtask

  // Reference behaviour: memory as a flat byte array.
  function automatic resp_t modelAccess(input logic [31:0] a, input int c, input logic w,
                                        input logic [31:0] d);
    resp_t r;
    int    n, off, base;
    bit    err;
    err = 1'b0;
`ifdef DATA_MEM_RESP_ERR_CHECK_EN
    n   = c;
    off = int'(a[1:0]);
    err = !(c == 1 || c == 2 || c == 4) || (c == 2 && a[0]) ||
          (c == 4 && a[1:0] != 2'b00) || (a >= 32'(4*DEPTH));
`else
    n   = (c > 4) ? 4 : c;
    off = int'(a % 4);
    if (n == 2) off = off - (off % 2);
    if (n == 4) off = 0;
`endif
    base   = int'((a / 4) % DEPTH) * 4;
    r.code = err ? C_ERR : C_DONE;
    r.rd   = '0;
    if (!err) begin
      for (int k = 0; k < n; k++) begin
        if (off + k < 4) begin
          if (w) mem_model[base + off + k] = d[8*k +: 8];
          else   r.rd[8*k +: 8] = mem_model[base + off + k];
        end
      end
    end
    return r;
  endfunction

  // Issue one request, optionally scrambling the inputs while BUSY, and wait
  // for its response.
  task automatic applyStimulus(input logic [31:0] a, input logic [2:0] c, input logic w,
                               input logic [31:0] d, input bit scramble);
    int busy;
    bit seen;
    @(negedge clk);
    checkCode("idle_before_req", code, C_IDLE);
    addr = a; cnt = c; we = w; wdata = d;
    exp_q.push_back(modelAccess(a, int'(c), w, d));
    busy = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (code == C_BUSY) begin
        busy++;
        if (scramble) begin
          addr  = $urandom;
          wdata = $urandom;
          we    = 1'($urandom_range(0, 1));
          cnt   = 3'($urandom_range(1, 7));
        end
      end else if (code == C_DONE || code == C_ERR) begin
        seen = 1'b1;
      end
    end
    checkOutput("resp_seen", 32'(seen), 32'd1);
    checkOutput("busy_cycles", 32'(busy), 32'(LAT));
    cnt = '0;
  endtask

  // Scoreboard monitor: pops one expectation per DONE/ERR cycle.
  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (aresetn === 1'b1 && (code == C_DONE || code == C_ERR)) begin
        if (exp_q.size() == 0) begin
          checkCode("unexpected_resp", code, C_IDLE);
        end else begin
          e = exp_q.pop_front();
          checkCode("resp_code", code, e.code);
          checkOutput("resp_rd_data", rdata, e.rd);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  exp_code;
    logic [31:0] a;
    aresetn = 1'b0;
    addr = '0; wdata = '0; we = 1'b0; cnt = '0;
    addr0 = '0; wdata0 = '0; we0 = 1'b0; cnt0 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkCode("reset_code", code, C_IDLE);
    checkOutput("reset_rd_data", rdata, 32'd0);
    checkCode("reset_code_l0", code0, C_IDLE);
    aresetn = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      applyStimulus(32'(4*i), 3'd4, 1'b1, $urandom, 1'b0);

    applyStimulus(32'h10, 3'd4, 1'b1, 32'hDEADBEEF, 1'b0);
    applyStimulus(32'h10, 3'd4, 1'b0, 32'h0, 1'b0);
    checkOutput("load_deadbeef", rdata, 32'hDEADBEEF);
    applyStimulus(32'h10, 3'd4, 1'b1, 32'h11223344, 1'b0);
    applyStimulus(32'h13, 3'd1, 1'b1, 32'h000000AA, 1'b0);
    applyStimulus(32'h10, 3'd4, 1'b0, 32'h0, 1'b0);
    checkOutput("load_after_byte", rdata, 32'hAA223344);
    applyStimulus(32'h12, 3'd2, 1'b0, 32'h0, 1'b0);
    checkOutput("load_half", rdata, 32'h0000AA22);
    applyStimulus(32'h10, 3'd4, 1'b0, 32'h0, 1'b1);
    applyStimulus(32'h11, 3'd2, 1'b1, 32'h0000BEEF, 1'b0);
    applyStimulus(32'h10, 3'd4, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'(4*DEPTH), 3'd4, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'h20, 3'd4, 1'b0, 32'h0, 1'b1);

    // Store abandoned by reset during WAIT
    applyStimulus(32'h10, 3'd4, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    addr = 32'h10; cnt = 3'd4; we = 1'b1; wdata = 32'h55667788;
    @(negedge clk);
    checkCode("busy_before_reset", code, C_BUSY);
    #1 aresetn = 1'b0;
    #1;
    checkCode("reset_mid_code", code, C_IDLE);
    checkOutput("reset_mid_rd_data", rdata, 32'd0);
    @(negedge clk);
    cnt = '0;
    aresetn = 1'b1;
    applyStimulus(32'h10, 3'd4, 1'b0, 32'h0, 1'b0);

    for (int t = 0; t < 150; t++) begin
      a = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH - 1));
      applyStimulus(a, 3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), $urandom,
                    1'($urandom_range(0, 1)));
    end

    // Zero-latency instance: single store, then a held load
    @(negedge clk);
    addr0 = 32'h20; cnt0 = 3'd4; we0 = 1'b1; wdata0 = 32'hCAFEF00D;
    @(negedge clk);
    checkCode("l0_store_code", code0, C_DONE);
    checkOutput("l0_store_rd_data", rdata0, 32'd0);
    cnt0 = '0;
    @(negedge clk);
    checkCode("l0_idle_after_store", code0, C_IDLE);
    addr0 = 32'h20; cnt0 = 3'd4; we0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_code = (i % 2 == 0) ? C_DONE : C_IDLE;
      checkCode("l0_held_code", code0, exp_code);
      checkOutput("l0_held_rd_data", rdata0, 32'hCAFEF00D);
    end
    cnt0 = '0;

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
